load_store_unit: RTL and testbench
==================================

# load_store_unit

Multicycle load/store unit between the CPU datapath and the data memory port. Accepts one load or store request at a time from the control FSM, which stalls until the response arrives. Drives a word-addressed memory with byte enables, waits for memory acknowledge, sign- or zero-extends load data, and reports errors for bad sizes, misalignment and memory timeout.

## Interface
Parameters:
- TIMEOUT, default 15: maximum BUSY cycles waiting for mem_ack before aborting (legal range 1–255).

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (size/sign)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the value is in the low bits
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request failed
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_be  out  4  byte enables
- mem_addr  out  30  word address (req_addr[31:2])
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  memory read word
- mem_ack  in  1  memory completion; valid only while mem_en is high

## Operation
- FSM states:
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) registers addr, funct3, write and wdata. The next state is BUSY, or RESP with error set if the request is invalid or misaligned.
  - BUSY: mem_en=1 and memory outputs are driven from the registered request. If mem_ack=1, the unit captures the result and moves to RESP. Otherwise the timeout counter increments; when it reaches TIMEOUT, the unit sets the error flag and moves to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then the FSM returns to IDLE.
- Loads, by funct3:
  - 000 lb: byte at lane addr[1:0], sign-extended.
  - 001 lh: halfword at addr[1], sign-extended.
  - 010 lw: full word.
  - 100 lbu and 101 lhu: zero-extended.
  - 011, 110 and 111 are invalid and produce err.
- Stores, by funct3:
  - 000 sb: mem_be = 1<<addr[1:0]; wdata[7:0] is replicated to all four lanes.
  - 001 sh: mem_be = 0011 or 1100 by addr[1]; wdata[15:0] is replicated to both halves.
  - 010 sw: mem_be = 1111.
  - Any other funct3 is invalid and produces err.
- For loads, mem_we=0 and mem_be=1111.
- For invalid requests, memory is never accessed: mem_en stays 0.
- Errors force resp_rdata=0. Memory writes are never retried.
- mem_ack while not in BUSY is ignored.
- req_valid while not in IDLE is ignored. The requester must hold its request until req_ready is high.

## Timing
- Reset values:
  - state = IDLE, so req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - timeout counter = 0.
- Reset asserted mid-access aborts the access. mem_en is 0 from the edge at which reset is sampled. No response is generated.
- Zero-wait memory (ack in the first BUSY cycle): handshake at edge N, BUSY in cycle N..N+1, resp_valid high in cycle N+2 for one cycle.
- Latency = 2 + W cycles, where W is the number of wait cycles before ack.
- Error path with no memory access: resp_valid one cycle after the handshake edge (latency 1).
- Timeout: resp_valid with resp_err=1 after 1 + TIMEOUT BUSY cycles. The timeout counter is cleared on entering BUSY.
- resp_rdata and resp_err are registered. They are stable while resp_valid=1, and resp_rdata returns to 0 in IDLE.
- Memory outputs are registered. mem_en deasserts on the edge that samples mem_ack=1.
- Back-to-back: the next request is accepted in the first IDLE cycle after RESP.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - lh/lhu/sh with addr[0]=1 produce resp_err=1 with no memory access.
  - lw/sw with addr[1:0]≠0 produce resp_err=1 with no memory access.
- LSU_MISALIGN_TRAP_EN undefined:
  - Misaligned low address bits are cleared to the natural alignment: addr[0] for halfwords, addr[1:0] for words.
  - The access then proceeds normally, and err is raised only for invalid funct3 or timeout.

## Test plan
- Word load, zero-wait memory: memory word 0x4 = 0x8000_00F0; lw at addr 0x10 maps to mem_addr=0x4. Expect resp_rdata=0x8000_00F0, resp_err=0, resp_valid exactly 2 cycles after the handshake.
- Byte and half extension: memory word 0x4 = 0x8000_00F0.
  - lb at 0x10 → 0xFFFF_FFF0.
  - lbu at 0x10 → 0x0000_00F0.
  - lh at 0x12 → 0xFFFF_8000.
  - lhu at 0x12 → 0x0000_8000.
- Store lanes: sb wdata=0x1234_56AB at addr 0x21 → mem_be=0010, mem_wdata=0xABAB_ABAB, mem_we=1. sh wdata=0xCAFE at 0x22 → mem_be=1100, mem_wdata=0xCAFE_CAFE.
- Wait states and timeout:
  - ack after 3 wait cycles → resp_valid at latency 5.
  - no ack with TIMEOUT=15 → resp_err=1, resp_rdata=0 after 16 BUSY cycles, then req_ready=1.
- Misalignment: lw at 0x13.
  - With LSU_MISALIGN_TRAP_EN: resp_err=1 at latency 1, mem_en never asserted.
  - Without it: mem_addr=0x4, normal response. funct3=011 load → err in both builds.
- Reset mid-access: assert reset during BUSY with no ack. Expect mem_en=0, req_ready=1 and no resp_valid after release. A following lw completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: word-addressed memory port with byte enables, load extension and error reporting.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned accesses instead of force-aligning them).
module load_store_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_reg, state_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic [1:0]  addr_lo_reg, addr_lo_next;
  logic [7:0]  count_reg, count_next;
  logic        resp_valid_reg, resp_valid_next;
  logic        resp_err_reg, resp_err_next;
  logic [31:0] resp_rdata_reg, resp_rdata_next;
  logic        mem_en_reg, mem_en_next;
  logic        mem_we_reg, mem_we_next;
  logic [3:0]  mem_be_reg, mem_be_next;
  logic [29:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;

  logic        req_bad;
  logic [1:0]  req_lo;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] load_data;
  logic [7:0]  lane_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  function automatic logic funct3_ok(input logic write, input logic [2:0] f3);
    if (write)
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
             (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  assign req_bad = !funct3_ok(req_write, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
  assign req_lo  = req_addr[1:0];
`else
  // Misaligned halfword/word accesses silently drop the offending low bits.
  function automatic logic [1:0] aligned_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return {lo[1], 1'b0};
      2'b10:   return 2'b00;
      default: return lo;
    endcase
  endfunction

  assign req_bad = !funct3_ok(req_write, req_funct3);
  assign req_lo  = aligned_lo(req_funct3, req_addr[1:0]);
`endif

  // Store lane steering from the (possibly force-aligned) low address bits.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'd0;
    if (req_write) begin
      case (req_funct3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << req_lo;
          st_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          st_be    = req_lo[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = req_wdata;
        end
      endcase
    end else begin
      st_be = 4'b1111;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = mem_rdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = lane_byte[addr_lo_reg];
  assign sel_half = addr_lo_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_data = 32'd0;
    case (funct3_reg)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_data = mem_rdata;
      3'b100:  load_data = {24'd0, sel_byte};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    funct3_next     = funct3_reg;
    addr_lo_next    = addr_lo_reg;
    count_next      = count_reg;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = 32'd0;
    mem_en_next     = mem_en_reg;
    mem_we_next     = mem_we_reg;
    mem_be_next     = mem_be_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          funct3_next  = req_funct3;
          addr_lo_next = req_lo;
          if (req_bad) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else begin
            state_next     = BUSY;
            count_next     = 8'd0;
            mem_en_next    = 1'b1;
            mem_we_next    = req_write;
            mem_be_next    = st_be;
            mem_addr_next  = req_addr[31:2];
            mem_wdata_next = st_wdata;
          end
        end
      end

      BUSY: begin
        if (mem_ack || (count_reg == TIMEOUT_CNT)) begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          // An ack on the final counted cycle still wins over the timeout.
          resp_err_next   = !mem_ack;
          resp_rdata_next = (mem_ack && !mem_we_reg) ? load_data : 32'd0;
          mem_en_next     = 1'b0;
          mem_we_next     = 1'b0;
          mem_be_next     = 4'b0000;
          mem_addr_next   = 30'd0;
          mem_wdata_next  = 32'd0;
        end else begin
          count_next = count_reg + 8'd1;
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      funct3_reg     <= 3'd0;
      addr_lo_reg    <= 2'd0;
      count_reg      <= 8'd0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'd0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_be_reg     <= 4'b0000;
      mem_addr_reg   <= 30'd0;
      mem_wdata_reg  <= 32'd0;
    end else begin
      state_reg      <= state_next;
      funct3_reg     <= funct3_next;
      addr_lo_reg    <= addr_lo_next;
      count_reg      <= count_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
      mem_en_reg     <= mem_en_next;
      mem_we_reg     <= mem_we_next;
      mem_be_reg     <= mem_be_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;
  assign mem_en     = mem_en_reg;
  assign mem_we     = mem_we_reg;
  assign mem_be     = mem_be_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written corner sequences, and random traffic vs a byte-level memory model.
module tb_load_store_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory seen through the DUT port, plus the model's own view of memory.
  logic [31:0] mem_dut [64];
  logic [31:0] mem_ref [64];
  int          ack_wait = 0;
  bit          no_ack = 1'b0;
  bit          mem_en_seen = 1'b0;
  int          busy_cycles = 0;
  logic [3:0]  cap_be;
  logic [31:0] cap_wd;
  logic        cap_we;
  logic [29:0] cap_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_wait wait cycles, applies byte-enabled writes on ack.
  always @(posedge clk) begin
    if (mem_en && mem_ack && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem_dut[mem_addr[5:0]][8*b +: 8] = mem_wdata[8*b +: 8];
    end
    #1;
    if (mem_en) begin
      if (!mem_en_seen) begin
        cap_be   = mem_be;
        cap_wd   = mem_wdata;
        cap_we   = mem_we;
        cap_addr = mem_addr;
      end
      mem_en_seen = 1'b1;
      busy_cycles++;
      mem_ack   = !no_ack && (busy_cycles == ack_wait + 1);
      mem_rdata = mem_ack ? mem_dut[mem_addr[5:0]] : $urandom;
    end else begin
      busy_cycles = 0;
      mem_ack     = 1'b0;
      mem_rdata   = $urandom;
    end
  end

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int wt, input bit na,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    ack_wait    = wt;
    no_ack      = na;
    mem_en_seen = 1'b0;
    req_valid   = 1'b1;
    req_write   = wr;
    req_funct3  = f3;
    req_addr    = a;
    req_wdata   = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    rd  = 32'd0;
    er  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        er  = resp_err;
        break;
      end
    end
    if (lat == 0) begin
      check("resp_seen", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
      check("ready_after_resp", {31'd0, req_ready}, 32'd1);
      check("rdata_idle_zero", resp_rdata, 32'd0);
    end
    no_ack = 1'b0;
  endtask

  // Reference model: byte-granular memory, sizes and sign rules computed arithmetically.
  task automatic ref_txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int wt, input bit na,
                         output logic [31:0] rd, output logic er, output int lat, output bit acc);
    int          sz;
    bit          ok;
    logic [31:0] ea;
    logic [31:0] v;
    longint      lim;
    rd = 32'd0; er = 1'b0; lat = 1; acc = 1'b0;
    ok = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
    if (!ok || (a % sz) != 0) begin er = 1'b1; return; end
`else
    if (!ok) begin er = 1'b1; return; end
`endif
    ea  = a - (a % sz);
    acc = 1'b1;
    if (na) begin er = 1'b1; lat = TIMEOUT + 2; return; end
    lat = 2 + wt;
    if (wr) begin
      for (int i = 0; i < sz; i++)
        mem_ref[(ea + i) >> 2][8*((ea + i) % 4) +: 8] = wd[8*i +: 8];
    end else begin
      v = mem_ref[ea >> 2] >> (8 * (ea % 4));
      if (sz < 4) begin
        lim = 64'd1 << (8 * sz);
        v   = 32'(longint'(v) % lim);
        if (!f3[2] && (longint'(v) >= lim / 2)) v = 32'(longint'(v) - lim);
      end
      rd = v;
    end
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          wt;
    bit          na;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    bit          exp_acc;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] rd, erd;
    logic        er, eer;
    int          lat, elat;
    bit          eacc, saw;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    int          wt;
    bit          na;

    vecs[0]  = '{1'b0, 3'd2, 32'h10, 32'h0,        0, 1'b0, 32'h8000_00F0, 1'b0, 2,  1'b1, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 3'd0, 32'h10, 32'h0,        0, 1'b0, 32'hFFFF_FFF0, 1'b0, 2,  1'b1, 4'hF, 32'h0};
    vecs[2]  = '{1'b0, 3'd4, 32'h10, 32'h0,        0, 1'b0, 32'h0000_00F0, 1'b0, 2,  1'b1, 4'hF, 32'h0};
    vecs[3]  = '{1'b0, 3'd1, 32'h12, 32'h0,        0, 1'b0, 32'hFFFF_8000, 1'b0, 2,  1'b1, 4'hF, 32'h0};
    vecs[4]  = '{1'b0, 3'd5, 32'h12, 32'h0,        0, 1'b0, 32'h0000_8000, 1'b0, 2,  1'b1, 4'hF, 32'h0};
    vecs[5]  = '{1'b0, 3'd2, 32'h10, 32'h0,        3, 1'b0, 32'h8000_00F0, 1'b0, 5,  1'b1, 4'hF, 32'h0};
    vecs[6]  = '{1'b0, 3'd2, 32'h10, 32'h0,        0, 1'b1, 32'h0,         1'b1, 17, 1'b1, 4'hF, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[7]  = '{1'b0, 3'd2, 32'h13, 32'h0,        0, 1'b0, 32'h0,         1'b1, 1,  1'b0, 4'h0, 32'h0};
`else
    vecs[7]  = '{1'b0, 3'd2, 32'h13, 32'h0,        0, 1'b0, 32'h8000_00F0, 1'b0, 2,  1'b1, 4'hF, 32'h0};
`endif
    vecs[8]  = '{1'b0, 3'd3, 32'h10, 32'h0,        0, 1'b0, 32'h0,         1'b1, 1,  1'b0, 4'h0, 32'h0};
    vecs[9]  = '{1'b1, 3'd0, 32'h21, 32'h1234_56AB, 0, 1'b0, 32'h0,        1'b0, 2,  1'b1, 4'h2, 32'hABAB_ABAB};
    vecs[10] = '{1'b1, 3'd1, 32'h22, 32'h0000_CAFE, 0, 1'b0, 32'h0,        1'b0, 2,  1'b1, 4'hC, 32'hCAFE_CAFE};
    vecs[11] = '{1'b1, 3'd3, 32'h20, 32'h5555_5555, 0, 1'b0, 32'h0,        1'b1, 1,  1'b0, 4'h0, 32'h0};

    for (int i = 0; i < 64; i++) mem_dut[i] = 32'd0;
    mem_dut[4] = 32'h8000_00F0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_mem_addr", {2'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].wt, vecs[i].na, rd, er, lat);
      $display("vec %0d wr=%0d f3=%0d addr=%h rdata=%h err=%0d lat=%0d",
               i, vecs[i].wr, vecs[i].f3, vecs[i].addr, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_access", i), {31'd0, mem_en_seen}, {31'd0, vecs[i].exp_acc});
      if (vecs[i].exp_acc) begin
        check($sformatf("vec%0d_be", i), {28'd0, cap_be}, {28'd0, vecs[i].exp_be});
        check($sformatf("vec%0d_mwdata", i), cap_wd, vecs[i].exp_mwd);
        check($sformatf("vec%0d_we", i), {31'd0, cap_we}, {31'd0, vecs[i].wr});
        check($sformatf("vec%0d_maddr", i), {2'd0, cap_addr}, vecs[i].addr >> 2);
      end
    end
    check("sb_sh_word", mem_dut[8], 32'hCAFE_AB00);

    // Reset while waiting on a memory that never acks.
    @(negedge clk);
    no_ack = 1'b1; ack_wait = 0; mem_en_seen = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_mem_en", {31'd0, mem_en}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_mem_en", {31'd0, mem_en}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) saw = 1'b1;
    end
    check("abort_no_resp", {31'd0, saw}, 32'd0);
    no_ack = 1'b0;
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, rd, er, lat);
    $display("post-reset lw rdata=%h err=%0d lat=%0d", rd, er, lat);
    check("post_reset_rdata", rd, 32'h8000_00F0);
    check("post_reset_err", {31'd0, er}, 32'd0);
    check("post_reset_lat", 32'(lat), 32'd2);

    // Random traffic against the model.
    for (int i = 0; i < 64; i++) mem_ref[i] = mem_dut[i];
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 63));
      wd = $urandom;
      wt = $urandom_range(0, 3);
      na = ($urandom_range(0, 15) == 0);
      ref_txn(wr, f3, a, wd, wt, na, erd, eer, elat, eacc);
      do_req(wr, f3, a, wd, wt, na, rd, er, lat);
      $display("rnd %0d wr=%0d f3=%0d addr=%h wd=%h wait=%0d noack=%0d rdata=%h err=%0d lat=%0d",
               i, wr, f3, a, wd, wt, na, rd, er, lat);
      check($sformatf("rnd%0d_rdata", i), rd, erd);
      check($sformatf("rnd%0d_err", i), {31'd0, er}, {31'd0, eer});
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
      check($sformatf("rnd%0d_access", i), {31'd0, mem_en_seen}, {31'd0, eacc});
      if (wr) check($sformatf("rnd%0d_memword", i), mem_dut[a >> 2], mem_ref[a >> 2]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
